// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central hazard/stall controller for a 5-stage RV32 pipeline.
//   - EX operand forwarding selects (MEM beats WB, x0 never forwarded)
//   - load-use stall (FWD_EN=1) or full RAW stall (FWD_EN=0)
//   - taken-branch flush of IF-ID and ID-EX
//   - whole-pipe freeze while a data-memory access waits, with timeout
//   - saturating cycle / stall / flush counters and a sticky timeout flag
//
// Ports
//   clk, rst                        clock (rising edge), async reset (active-low)
//   id_rs1/id_rs2, id_use_rs1/2     ID source registers and their use flags
//   ex_rs1/ex_rs2, ex_rd            EX sources and destination
//   ex_reg_write, ex_mem_re         EX writes RF / EX is a load
//   mem_rd, mem_reg_write           MEM destination / writes RF
//   wb_rd, wb_reg_write             WB destination / writes RF
//   br_taken_ex                     branch or jump in EX resolved taken
//   dmem_req, dmem_ready            data-memory handshake of the MEM instruction
//   fwd_a_sel/fwd_b_sel             00 RF, 01 EX/MEM alu_out, 10 WB data
//   pc_en, ifid_en, idex_en, exmem_en   pipeline register advance enables
//   ifid_flush, idex_flush          NOP / bubble insert
//   memwb_bubble                    bubble into MEM-WB
//   dmem_err                        sticky: a memory access timed out
//   cyc_cnt, stall_cnt, flush_cnt   saturating performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RF_SIZE     = 5,
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RF_SIZE-1:0]   id_rs1,
    input  logic [RF_SIZE-1:0]   id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [RF_SIZE-1:0]   ex_rs1,
    input  logic [RF_SIZE-1:0]   ex_rs2,
    input  logic [RF_SIZE-1:0]   ex_rd,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_re,
    input  logic [RF_SIZE-1:0]   mem_rd,
    input  logic                 mem_reg_write,
    input  logic [RF_SIZE-1:0]   wb_rd,
    input  logic                 wb_reg_write,
    input  logic                 br_taken_ex,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_bubble,
    output logic                 dmem_err,
    output logic [CNT_WIDTH-1:0] cyc_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 dmem_err_q, dmem_err_d;
    logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic       freeze;
    logic       hazard;
    logic       stall_ev;
    logic       flush_ev;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // -----------------------------------------------------------------------
    // Forwarding: the younger producer (MEM) wins over WB; x0 is never
    // forwarded because it always reads as zero.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [RF_SIZE-1:0] rs);
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
            return 2'b01;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    // True when a producer with destination rd overwrites a source the ID
    // instruction actually reads.
    function automatic logic id_reads(input logic [RF_SIZE-1:0] rd, input logic wr);
        return wr && (rd != '0) &&
               ((id_use_rs1 && (id_rs1 == rd)) || (id_use_rs2 && (id_rs2 == rd)));
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic               en);
        if (en && (v != '1))
            return v + CNT_WIDTH'(1);
        return v;
    endfunction

    always_comb begin
        // With forwarding, only a load in EX is too late to forward to ID's
        // consumer; without it every in-flight producer must drain first.
        if (FWD_EN != 0) begin
            fwd_a_raw = fwd_sel(ex_rs1);
            fwd_b_raw = fwd_sel(ex_rs2);
            hazard    = id_reads(ex_rd, ex_mem_re);
        end else begin
            fwd_a_raw = 2'b00;
            fwd_b_raw = 2'b00;
            hazard    = id_reads(ex_rd, ex_reg_write) ||
                        id_reads(mem_rd, mem_reg_write) ||
                        id_reads(wb_rd, wb_reg_write);
        end
    end

    // -----------------------------------------------------------------------
    // Memory-wait FSM. The cycle that sees ready (or the timeout) is the
    // release cycle: not frozen, the pipe advances normally.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dmem_err_d = dmem_err_q;
        freeze     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    dmem_err_d = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pipeline controls. Defaults are the freeze/reset pattern; a branch held
    // in EX during a freeze therefore flushes only on the release cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b1;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;
        stall_ev     = 1'b0;
        flush_ev     = 1'b0;
        if (rst) begin
            fwd_a_sel = fwd_a_raw;
            fwd_b_sel = fwd_b_raw;
            if (freeze) begin
                stall_ev = 1'b1;
            end else if (br_taken_ex) begin
                // Squashes both younger instructions; any pending hazard
                // belonged to one of them and is dropped.
                pc_en        = 1'b1;
                ifid_en      = 1'b1;
                idex_en      = 1'b1;
                exmem_en     = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                memwb_bubble = 1'b0;
                flush_ev     = 1'b1;
            end else if (hazard) begin
                idex_en      = 1'b1;
                idex_flush   = 1'b1;
                exmem_en     = 1'b1;
                memwb_bubble = 1'b0;
                stall_ev     = 1'b1;
            end else begin
                pc_en        = 1'b1;
                ifid_en      = 1'b1;
                idex_en      = 1'b1;
                exmem_en     = 1'b1;
                memwb_bubble = 1'b0;
            end
        end
    end

    always_comb begin
        cyc_cnt_d   = sat_inc(cyc_cnt_q, 1'b1);
        stall_cnt_d = sat_inc(stall_cnt_q, stall_ev);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_ev);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            dmem_err_q  <= 1'b0;
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dmem_err_q  <= dmem_err_d;
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign dmem_err  = dmem_err_q;
    assign cyc_cnt   = cyc_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
//   u_dut (FWD_EN=1, 32-bit counters) and u_nf (FWD_EN=0, 4-bit counters).
//   Expected values are queued when stimulus is applied and compared when
//   the outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_re;
    logic       mem_reg_write, wb_reg_write, br_taken_ex, dmem_req, dmem_ready;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, dmem_err;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    logic [1:0]  nf_fwd_a_sel, nf_fwd_b_sel;
    logic        nf_pc_en, nf_ifid_en, nf_idex_en, nf_exmem_en, nf_ifid_flush, nf_idex_flush;
    logic        nf_memwb_bubble, nf_dmem_err;
    logic [3:0]  nf_cyc_cnt, nf_stall_cnt, nf_flush_cnt;

    pipe_hazard_ctrl #(.RF_SIZE(5), .FWD_EN(1), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_re(ex_mem_re), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .br_taken_ex(br_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .dmem_err(dmem_err), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.RF_SIZE(5), .FWD_EN(0), .MEM_TIMEOUT(16), .CNT_WIDTH(4)) u_nf (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_re(ex_mem_re), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .br_taken_ex(br_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_a_sel(nf_fwd_a_sel), .fwd_b_sel(nf_fwd_b_sel),
        .pc_en(nf_pc_en), .ifid_en(nf_ifid_en), .idex_en(nf_idex_en), .exmem_en(nf_exmem_en),
        .ifid_flush(nf_ifid_flush), .idex_flush(nf_idex_flush), .memwb_bubble(nf_memwb_bubble),
        .dmem_err(nf_dmem_err), .cyc_cnt(nf_cyc_cnt), .stall_cnt(nf_stall_cnt),
        .flush_cnt(nf_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // Control vector: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_FRZ  = 7'b0000_001;
    localparam logic [6:0] C_RST  = 7'b0000_001;
    localparam logic [6:0] C_HAZ  = 7'b0011_010;
    localparam logic [6:0] C_BR   = 7'b1111_110;

    typedef enum {K_CTRL, K_FWDA, K_FWDB, K_CYC, K_STALL, K_FLUSH, K_ERR,
                  K_NF_CTRL, K_NF_FWDA, K_NF_CYC, K_NF_STALL} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] val;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Model of the main instance's registered state.
    logic [31:0] e_cyc, e_stall, e_flush;
    logic        e_err;

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_CTRL:     return {25'd0, pc_en, ifid_en, idex_en, exmem_en,
                                ifid_flush, idex_flush, memwb_bubble};
            K_FWDA:     return {30'd0, fwd_a_sel};
            K_FWDB:     return {30'd0, fwd_b_sel};
            K_CYC:      return cyc_cnt;
            K_STALL:    return stall_cnt;
            K_FLUSH:    return flush_cnt;
            K_ERR:      return {31'd0, dmem_err};
            K_NF_CTRL:  return {25'd0, nf_pc_en, nf_ifid_en, nf_idex_en, nf_exmem_en,
                                nf_ifid_flush, nf_idex_flush, nf_memwb_bubble};
            K_NF_FWDA:  return {30'd0, nf_fwd_a_sel};
            K_NF_CYC:   return {28'd0, nf_cyc_cnt};
            K_NF_STALL: return {28'd0, nf_stall_cnt};
            default:    return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input kind_e k, input logic [31:0] v, input string tag);
        sb_t e;
        e.kind = k;
        e.val  = v;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.kind);
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s/%s: observed=%0h expected=%0h", e.tag, e.kind.name(), obs, e.val);
            end
        end
    endtask

    // One clock cycle: queue the main instance's expectations for the current
    // inputs, compare on the falling edge, then advance the counter model.
    task automatic step(input string tag, input logic [6:0] ctrl, input bit st, input bit fl);
        push(K_CTRL, 32'(ctrl), tag);
        push(K_CYC, e_cyc, tag);
        push(K_STALL, e_stall, tag);
        push(K_FLUSH, e_flush, tag);
        push(K_ERR, 32'(e_err), tag);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        if (rst) begin
            e_cyc = e_cyc + 1;
            if (st) e_stall = e_stall + 1;
            if (fl) e_flush = e_flush + 1;
        end
    endtask

    initial begin
        rst = 1'b0;
        {id_rs1, id_rs2, ex_rs2, ex_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_re} = '0;
        {wb_reg_write, br_taken_ex, dmem_req, dmem_ready} = '0;
        e_cyc = 0; e_stall = 0; e_flush = 0; e_err = 1'b0;

        // Reset: outputs forced even though a forward condition is present.
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
        push(K_FWDA, 32'd0, "rst_fwd");
        push(K_NF_CTRL, 32'(C_RST), "rst_nf");
        step("rst", C_RST, 0, 0);
        rst = 1'b1;

        // 1 Forwarding priority and x0.
        wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs2 = 5'd5;
        push(K_FWDA, 32'd1, "fwd_mem"); push(K_FWDB, 32'd1, "fwd_mem");
        push(K_NF_FWDA, 32'd0, "fwd_nf");
        step("fwd_mem", C_NORM, 0, 0);
        mem_rd = 5'd0;
        push(K_FWDA, 32'd2, "fwd_wb"); push(K_FWDB, 32'd2, "fwd_wb");
        step("fwd_wb", C_NORM, 0, 0);
        mem_rd = 5'd5; mem_reg_write = 1'b0; ex_rs2 = 5'd6;
        push(K_FWDA, 32'd2, "fwd_nowr"); push(K_FWDB, 32'd0, "fwd_nowr");
        step("fwd_nowr", C_NORM, 0, 0);
        mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        push(K_FWDA, 32'd0, "fwd_x0"); push(K_FWDB, 32'd0, "fwd_x0");
        step("fwd_x0", C_NORM, 0, 0);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // 2 Load-use.
        ex_mem_re = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs2 = 5'd3;
        step("lu_unused", C_NORM, 0, 0);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step("lu_x0", C_NORM, 0, 0);
        ex_rd = 5'd3; id_rs1 = 5'd1; id_use_rs2 = 1'b1;
        step("lu_hit", C_HAZ, 1, 0);
        ex_mem_re = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        step("lu_after", C_NORM, 0, 0);
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;

        // 3 Memory wait: four frozen cycles, release on ready.
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("mw_frz", C_FRZ, 1, 0);
        dmem_ready = 1'b1;
        step("mw_rel", C_NORM, 0, 0);
        dmem_req = 1'b0; dmem_ready = 1'b0;
        step("mw_idle", C_NORM, 0, 0);

        // 4 Timeout: 16 frozen cycles, branch held during freeze fires on release.
        dmem_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step("tmo_frz", C_FRZ, 1, 0);
            if (i == 5) br_taken_ex = 1'b1;
        end
        step("tmo_rel", C_BR, 0, 1);
        e_err = 1'b1;
        dmem_req = 1'b0; br_taken_ex = 1'b0;
        step("tmo_after", C_NORM, 0, 0);
        step("tmo_sticky", C_NORM, 0, 0);

        // 5 Branch and load-use in the same cycle: branch wins.
        ex_mem_re = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        br_taken_ex = 1'b1;
        step("br_lu", C_BR, 0, 1);
        ex_mem_re = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; id_use_rs1 = 1'b0;
        br_taken_ex = 1'b0;
        push(K_NF_CYC, 32'd15, "nf_sat");
        step("br_after", C_NORM, 0, 0);

        // 6 No-forwarding instance: reset, then RAW on WB stalls until the write drops.
        rst = 1'b0;
        e_cyc = 0; e_stall = 0; e_flush = 0; e_err = 1'b0;
        push(K_NF_CYC, 32'd0, "rst2_nf"); push(K_NF_STALL, 32'd0, "rst2_nf");
        step("rst2", C_RST, 0, 0);
        rst = 1'b1;
        wb_rd = 5'd7; wb_reg_write = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(K_NF_CTRL, 32'(C_HAZ), "nf_raw");
            push(K_NF_STALL, 32'(k), "nf_raw");
            push(K_NF_CYC, 32'(k), "nf_raw");
            step("nf_raw_main", C_NORM, 0, 0);
        end
        wb_reg_write = 1'b0;
        push(K_NF_CTRL, 32'(C_NORM), "nf_clear");
        push(K_NF_STALL, 32'd3, "nf_clear");
        step("nf_clear_main", C_NORM, 0, 0);

        // Reset asserted in the middle of a memory wait.
        dmem_req = 1'b1;
        push(K_NF_CTRL, 32'(C_FRZ), "nf_mw");
        step("mw2_frz", C_FRZ, 1, 0);
        step("mw2_frz", C_FRZ, 1, 0);
        rst = 1'b0;
        e_cyc = 0; e_stall = 0; e_flush = 0;
        push(K_NF_CYC, 32'd0, "rst_mid_nf"); push(K_NF_STALL, 32'd0, "rst_mid_nf");
        step("rst_mid", C_RST, 0, 0);
        rst = 1'b1; dmem_req = 1'b0;
        push(K_NF_CTRL, 32'(C_NORM), "post_rst_nf");
        step("post_rst", C_NORM, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
